// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: KEY0/collision inputs and tick/status outputs of the game sequencer.
interface flappy_game_ctrl_if #(
    parameter int SCORE_W = 7
);
    logic               key;
    logic               collision;
    logic               bird_tick;
    logic               pipe_tick;
    logic               clear_field;
    logic               game_active;
    logic               game_over;
    logic               loss_flash;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hi_score;
    modport master (
        output key, collision,
        input  bird_tick, pipe_tick, clear_field, game_active, game_over, loss_flash, score, hi_score
    );
    modport slave (
        input  key, collision,
        output bird_tick, pipe_tick, clear_field, game_active, game_over, loss_flash, score, hi_score
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: 8x8 Flappy Bird sequencer -- game FSM, bird/pipe tick dividers, score.
// Define FLAPPY_HISCORE_EN to build the best-score register; otherwise hi_score is 0.
module flappy_game_ctrl #(
    parameter int BIRD_DIV    = 1792,
    parameter int PIPE_MULT   = 2,
    parameter int PASS_EVERY  = 4,
    parameter int FLASH_TICKS = 6,
    parameter int SCORE_W     = 7
) (
    input logic               i_clk,
    input logic               i_rst,
    flappy_game_ctrl_if.slave io_bus
);
    localparam int DW = $clog2(BIRD_DIV);
    localparam int PW = $clog2(PIPE_MULT + 1);
    localparam int QW = $clog2(PASS_EVERY + 1);
    localparam int FW = $clog2(FLASH_TICKS + 1);
    localparam logic [SCORE_W-1:0] SMAX = '1;

    typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} state_t;

    state_t             r_state;
    logic               r_key_q;
    logic [DW-1:0]      r_div;
    logic [PW-1:0]      r_pc;
    logic [QW-1:0]      r_pass;
    logic [FW-1:0]      r_fc;
    logic [SCORE_W-1:0] r_score;
    logic               r_bird_tick, r_pipe_tick, r_clear, r_active, r_over, r_flash;
    logic               w_key_rise, w_div_end, w_pc_end, w_pass_end, w_fc_end;

    assign w_key_rise = io_bus.key & ~r_key_q;
    assign w_div_end  = r_div == DW'(BIRD_DIV - 1);
    assign w_pc_end   = r_pc == PW'(PIPE_MULT - 1);
    assign w_pass_end = r_pass == QW'(PASS_EVERY - 1);
    assign w_fc_end   = r_fc == FW'(FLASH_TICKS - 1);

`ifdef FLAPPY_HISCORE_EN
    logic [SCORE_W-1:0] r_hi;
    always_ff @(posedge i_clk)
        if (i_rst)
            r_hi <= '0;
        else if (r_state == DYING && w_div_end && w_fc_end && r_score > r_hi)
            r_hi <= r_score;
    assign io_bus.hi_score = r_hi;
`else
    assign io_bus.hi_score = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_key_q     <= 1'b0;
            r_div       <= '0;
            r_pc        <= '0;
            r_pass      <= '0;
            r_fc        <= '0;
            r_score     <= '0;
            r_bird_tick <= 1'b0;
            r_pipe_tick <= 1'b0;
            r_clear     <= 1'b0;
            r_active    <= 1'b0;
            r_over      <= 1'b0;
            r_flash     <= 1'b0;
        end else begin
            r_key_q     <= io_bus.key;
            r_bird_tick <= 1'b0;
            r_pipe_tick <= 1'b0;
            r_clear     <= 1'b0;
            case (r_state)
                IDLE: if (w_key_rise) begin
                    r_state  <= PLAY;
                    r_clear  <= 1'b1;
                    r_active <= 1'b1;
                    r_score  <= '0;
                    r_pc     <= '0;
                    r_pass   <= '0;
                    r_div    <= '0;
                end
                PLAY: if (io_bus.collision) begin
                    // a collision swallows any tick that was due this cycle
                    r_state  <= DYING;
                    r_active <= 1'b0;
                    r_over   <= 1'b1;
                    r_flash  <= 1'b1;
                    r_fc     <= '0;
                    r_div    <= '0;
                end else begin
                    r_div <= w_div_end ? '0 : r_div + 1'b1;
                    if (w_div_end) begin
                        r_bird_tick <= 1'b1;
                        r_pc        <= w_pc_end ? '0 : r_pc + 1'b1;
                        if (w_pc_end) begin
                            r_pipe_tick <= 1'b1;
                            r_pass      <= w_pass_end ? '0 : r_pass + 1'b1;
                            if (w_pass_end && r_score != SMAX)
                                r_score <= r_score + 1'b1;
                        end
                    end
                end
                DYING: begin
                    r_div <= w_div_end ? '0 : r_div + 1'b1;
                    if (w_div_end) begin
                        r_bird_tick <= 1'b1;
                        r_flash     <= ~r_flash;
                        r_fc        <= r_fc + 1'b1;
                        if (w_fc_end) begin
                            r_state <= OVER;
                            r_flash <= 1'b1;
                            r_div   <= '0;
                        end
                    end
                end
                OVER: if (w_key_rise) begin
                    r_state <= IDLE;
                    r_clear <= 1'b1;
                    r_over  <= 1'b0;
                    r_flash <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                    r_over   <= 1'b0;
                    r_flash  <= 1'b0;
                    r_div    <= '0;
                end
            endcase
        end
    end

    assign io_bus.bird_tick   = r_bird_tick;
    assign io_bus.pipe_tick   = r_pipe_tick;
    assign io_bus.clear_field = r_clear;
    assign io_bus.game_active = r_active;
    assign io_bus.game_over   = r_over;
    assign io_bus.loss_flash  = r_flash;
    assign io_bus.score       = r_score;
endmodule
